// File: rtl/fpga_run_display.sv
// Board-level run controller for the arlet6502 wrapper: debounced start, CPU reset/run
// sequencing, saturating run-cycle counter and a parametrised hex seven-segment driver.
module fpga_run_display #(
    parameter int unsigned NUM_DIGITS      = 8,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned RESET_CYCLES    = 4,
    parameter bit          SEG_ACTIVE_LOW  = 1'b1,
    parameter bit          BLANK_LEADING   = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    start_i,
    input  logic                    mode_i,
    input  logic [DATA_W-1:0]       value_i,
    input  logic                    value_valid_i,
    output logic                    cpu_reset_o,
    output logic                    running_o,
    output logic [DATA_W-1:0]       cycle_count_o,
    output logic [7*NUM_DIGITS-1:0] seg_o
);

    localparam int unsigned DispW = 4 * NUM_DIGITS;
    localparam int unsigned SegW  = 7 * NUM_DIGITS;
    localparam int unsigned CopyW = (DATA_W < DispW) ? DATA_W : DispW;
    localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RcW   = $clog2(RESET_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StRstp, StRun, StHold} state_e;

    // Active-high a..g pattern (bit 0 = a).
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'h3F;
            4'h1: p = 7'h06;
            4'h2: p = 7'h5B;
            4'h3: p = 7'h4F;
            4'h4: p = 7'h66;
            4'h5: p = 7'h6D;
            4'h6: p = 7'h7D;
            4'h7: p = 7'h07;
            4'h8: p = 7'h7F;
            4'h9: p = 7'h6F;
            4'hA: p = 7'h77;
            4'hB: p = 7'h7C;
            4'hC: p = 7'h39;
            4'hD: p = 7'h5E;
            4'hE: p = 7'h79;
            4'hF: p = 7'h71;
            default: p = 7'h00;
        endcase
        return p;
    endfunction

    function automatic logic [SegW-1:0] encode(input logic [DispW-1:0] d);
        logic [SegW-1:0] s;
        logic            zero_above;
        logic [3:0]      nib;
        logic [6:0]      pat;
        s          = '0;
        zero_above = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            nib        = d[4*k +: 4];
            zero_above = zero_above & (nib == 4'h0);
            if (BLANK_LEADING && (k != 0) && zero_above) begin
                pat = 7'h00;
            end else begin
                pat = hex7(nib);
            end
            s[7*k +: 7] = SEG_ACTIVE_LOW ? ~pat : pat;
        end
        return s;
    endfunction

    localparam logic [SegW-1:0] SegReset = encode('0);

    // Input synchroniser and debounce
    logic           start_meta_q, start_s_q;
    logic           start_db_q, start_db_d;
    logic [DbW-1:0] db_cnt_q, db_cnt_d;

    always_comb begin
        db_cnt_d   = '0;
        start_db_d = start_db_q;
        if (start_s_q != start_db_q) begin
            if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
                start_db_d = ~start_db_q;
            end else begin
                db_cnt_d = db_cnt_q + DbW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            start_meta_q <= 1'b0;
            start_s_q    <= 1'b0;
            start_db_q   <= 1'b0;
            db_cnt_q     <= '0;
        end else begin
            start_meta_q <= start_i;
            start_s_q    <= start_meta_q;
            start_db_q   <= start_db_d;
            db_cnt_q     <= db_cnt_d;
        end
    end

    // Run-control FSM; outputs are set on the transition edge so they stay registered.
    state_e            state_q;
    logic [RcW-1:0]    rst_cnt_q;
    logic              cpu_reset_q, running_q;
    logic [DATA_W-1:0] count_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= StIdle;
            rst_cnt_q   <= '0;
            cpu_reset_q <= 1'b1;
            running_q   <= 1'b0;
            count_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle, StHold: begin
                    if (start_db_q) begin
                        state_q   <= StRstp;
                        rst_cnt_q <= '0;
                        count_q   <= '0;
                    end
                end
                StRstp: begin
                    count_q <= '0;
                    if (!start_db_q) begin
                        state_q <= StHold;
                    end else if (rst_cnt_q == RcW'(RESET_CYCLES - 1)) begin
                        state_q     <= StRun;
                        cpu_reset_q <= 1'b0;
                        running_q   <= 1'b1;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + RcW'(1);
                    end
                end
                StRun: begin
                    // The cycle that ends in HOLD was still a RUN cycle, so it counts.
                    if (count_q != '1) begin
                        count_q <= count_q + DATA_W'(1);
                    end
                    if (!start_db_q) begin
                        state_q     <= StHold;
                        cpu_reset_q <= 1'b1;
                        running_q   <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Value capture and display pipeline
    logic [DATA_W-1:0] value_q;
    logic [DATA_W-1:0] src_sel;
    logic [DispW-1:0]  disp_q, disp_d;
    logic [SegW-1:0]   seg_q;

    always_comb begin
        src_sel              = mode_i ? count_q : value_q;
        disp_d               = '0;
        disp_d[CopyW-1:0]    = src_sel[CopyW-1:0];
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            value_q <= '0;
            disp_q  <= '0;
            seg_q   <= SegReset;
        end else begin
            if (value_valid_i) begin
                value_q <= value_i;
            end
            disp_q <= disp_d;
            seg_q  <= encode(disp_q);
        end
    end

    assign cpu_reset_o   = cpu_reset_q;
    assign running_o     = running_q;
    assign cycle_count_o = count_q;
    assign seg_o         = seg_q;

endmodule

// File: tb/tb_fpga_run_display.sv
// Directed bench for fpga_run_display: default build, a leading-blank build and a 4-bit
// counter build all share one set of stimulus.
module tb_fpga_run_display;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        mode;
    logic [31:0] value_in;
    logic        value_valid;

    logic        cpu_reset, running;
    logic [31:0] cycle_count;
    logic [55:0] seg;
    logic        b_cpu_reset, b_running;
    logic [31:0] b_cycle_count;
    logic [55:0] b_seg;
    logic        s_cpu_reset, s_running;
    logic [3:0]  s_cycle_count;
    logic [55:0] s_seg;

    int checks = 0;
    int errors = 0;

    fpga_run_display u_dut (
        .clk_i(clk), .reset_ni(reset_n), .start_i(start), .mode_i(mode),
        .value_i(value_in), .value_valid_i(value_valid),
        .cpu_reset_o(cpu_reset), .running_o(running), .cycle_count_o(cycle_count), .seg_o(seg)
    );

    fpga_run_display #(.BLANK_LEADING(1'b1)) u_blank (
        .clk_i(clk), .reset_ni(reset_n), .start_i(start), .mode_i(mode),
        .value_i(value_in), .value_valid_i(value_valid),
        .cpu_reset_o(b_cpu_reset), .running_o(b_running), .cycle_count_o(b_cycle_count),
        .seg_o(b_seg)
    );

    fpga_run_display #(.DATA_W(4)) u_sat (
        .clk_i(clk), .reset_ni(reset_n), .start_i(start), .mode_i(mode),
        .value_i(value_in[3:0]), .value_valid_i(value_valid),
        .cpu_reset_o(s_cpu_reset), .running_o(s_running), .cycle_count_o(s_cycle_count),
        .seg_o(s_seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        int bad;
        reset_n = 1'b0; start = 1'b0; mode = 1'b1; value_in = '0; value_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cpu_reset !== 1'b1 || running !== 1'b0 || cycle_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: cpu_reset=%b running=%b count=%0d, want 1 0 0",
                     cpu_reset, running, cycle_count);
        end
        checks++;
        if (seg !== {8{7'h40}}) begin
            errors++;
            $display("FAIL reset_seg: got %h want %h", seg, {8{7'h40}});
        end
        checks++;
        if (b_seg !== {{7{7'h7F}}, 7'h40}) begin
            errors++;
            $display("FAIL reset_seg_blank: got %h want %h", b_seg, {{7{7'h7F}}, 7'h40});
        end
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (cpu_reset !== 1'b1 || running !== 1'b0 || cycle_count !== 32'd0 ||
                seg !== {8{7'h40}}) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_stable: %0d bad cycles, want 0", bad);
        end
    endtask

    task automatic test_glitch();
        int bad;
        bad = 0;
        start = 1'b1;
        repeat (10) @(negedge clk);
        start = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (cpu_reset !== 1'b1 || running !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL glitch_reject: %0d cycles left idle, want 0", bad);
        end
    endtask

    // 2 sync + 16 debounce + 1 FSM edge + 4 reset cycles = 23 edges from start to RUN.
    task automatic wait_run(input string tag);
        int n;
        int rstp_bad;
        n = 0;
        rstp_bad = 0;
        while (cpu_reset === 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
            if (n == 20 && (cycle_count !== 32'd0 || cpu_reset !== 1'b1)) rstp_bad++;
        end
        checks++;
        if (n != 23) begin
            errors++;
            $display("FAIL %s_latency: run after %0d cycles, want 23", tag, n);
        end
        checks++;
        if (rstp_bad != 0) begin
            errors++;
            $display("FAIL %s_rstp: count/cpu_reset wrong during reset pulse", tag);
        end
        checks++;
        if (running !== 1'b1 || cycle_count !== 32'd0) begin
            errors++;
            $display("FAIL %s_run_entry: running=%b count=%0d want 1 0", tag, running,
                     cycle_count);
        end
    endtask

    task automatic test_start();
        start = 1'b1;
        wait_run("start");
        repeat (10) @(negedge clk);
        checks++;
        if (cycle_count !== 32'd10 || s_cycle_count !== 4'd10) begin
            errors++;
            $display("FAIL count_10: got %0d / %0d want 10 / 10", cycle_count, s_cycle_count);
        end
        repeat (1990) @(negedge clk);
        checks++;
        if (cycle_count !== 32'd2000) begin
            errors++;
            $display("FAIL count_2000: got %0d want 2000", cycle_count);
        end
        checks++;
        if (s_cycle_count !== 4'hF) begin
            errors++;
            $display("FAIL saturate: got %h want f", s_cycle_count);
        end
    endtask

    task automatic test_stop_restart();
        int n;
        int bad;
        start = 1'b0;
        n = 0;
        while (running === 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 19 || cpu_reset !== 1'b1) begin
            errors++;
            $display("FAIL stop_latency: hold after %0d cycles cpu_reset=%b, want 19 1", n,
                     cpu_reset);
        end
        checks++;
        if (cycle_count !== 32'd2019) begin
            errors++;
            $display("FAIL hold_value: got %0d want 2019", cycle_count);
        end
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (cycle_count !== 32'd2019) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_frozen: %0d cycles moved, want 0", bad);
        end
        // 2019 = 0x7E3
        checks++;
        if (seg !== {{5{7'h40}}, 7'h78, 7'h06, 7'h30}) begin
            errors++;
            $display("FAIL hold_seg: got %h want %h", seg, {{5{7'h40}}, 7'h78, 7'h06, 7'h30});
        end
        checks++;
        if (b_seg !== {{5{7'h7F}}, 7'h78, 7'h06, 7'h30}) begin
            errors++;
            $display("FAIL hold_seg_blank: got %h want %h", b_seg,
                     {{5{7'h7F}}, 7'h78, 7'h06, 7'h30});
        end
        start = 1'b1;
        wait_run("restart");
        repeat (5) @(negedge clk);
        checks++;
        if (cycle_count !== 32'd5) begin
            errors++;
            $display("FAIL restart_count: got %0d want 5", cycle_count);
        end
    endtask

    task automatic test_value();
        // Mode switches on the same edge that captures the value.
        mode = 1'b0; value_valid = 1'b1; value_in = 32'h0123ABCD;
        @(negedge clk);
        value_valid = 1'b0; value_in = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++;
        if (seg === {7'h40, 7'h79, 7'h24, 7'h30, 7'h08, 7'h03, 7'h46, 7'h21}) begin
            errors++;
            $display("FAIL value_early: seg %h updated after 1 cycle, want 2", seg);
        end
        @(negedge clk);
        checks++;
        if (seg !== {7'h40, 7'h79, 7'h24, 7'h30, 7'h08, 7'h03, 7'h46, 7'h21}) begin
            errors++;
            $display("FAIL value_seg: got %h want %h", seg,
                     {7'h40, 7'h79, 7'h24, 7'h30, 7'h08, 7'h03, 7'h46, 7'h21});
        end
        checks++;
        if (b_seg !== {7'h7F, 7'h79, 7'h24, 7'h30, 7'h08, 7'h03, 7'h46, 7'h21}) begin
            errors++;
            $display("FAIL value_seg_blank: got %h want %h", b_seg,
                     {7'h7F, 7'h79, 7'h24, 7'h30, 7'h08, 7'h03, 7'h46, 7'h21});
        end
        value_valid = 1'b1; value_in = 32'h0000_00F5;
        @(negedge clk);
        value_valid = 1'b0; value_in = 32'h0;
        repeat (2) @(negedge clk);
        checks++;
        if (seg !== {{6{7'h40}}, 7'h0E, 7'h12} || b_seg !== {{6{7'h7F}}, 7'h0E, 7'h12}) begin
            errors++;
            $display("FAIL value_f5: got %h / %h want %h / %h", seg, b_seg,
                     {{6{7'h40}}, 7'h0E, 7'h12}, {{6{7'h7F}}, 7'h0E, 7'h12});
        end
        value_valid = 1'b1; value_in = 32'h0;
        @(negedge clk);
        value_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (b_seg !== {{7{7'h7F}}, 7'h40}) begin
            errors++;
            $display("FAIL value_zero_blank: got %h want %h", b_seg, {{7{7'h7F}}, 7'h40});
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (cpu_reset !== 1'b1 || running !== 1'b0 || cycle_count !== 32'd0 ||
            s_cycle_count !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: cpu_reset=%b running=%b count=%0d/%0d want 1 0 0/0",
                     cpu_reset, running, cycle_count, s_cycle_count);
        end
        checks++;
        if (seg !== {8{7'h40}}) begin
            errors++;
            $display("FAIL async_reset_seg: got %h want %h", seg, {8{7'h40}});
        end
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_start();
        test_stop_restart();
        test_value();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
